count_pwm_compare: RTL and testbench

- Compare stage directly downstream of the free-running N-bit counter. It consumes the counter's count value and produces a registered PWM waveform plus period/match event pulses.
- Duty updates are double-buffered so they take effect only on a period boundary, where the count wraps from all-ones to 0.
- Supports continuous and one-shot modes through a small enable/period FSM.

---
 rtl/count_pwm_compare.sv | 119 +++++++++++
 tb/tb_count_pwm_compare.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_pwm_compare.sv
// PWM compare stage fed by a free-running N-bit counter: double-buffered duty,
// continuous / one-shot sequencing, and registered pwm, wrap and match pulses.
module count_pwm_compare #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] count_i,
    input  logic         en_i,
    input  logic         mode_i,
    input  logic [N:0]   duty_in_i,
    input  logic         duty_load_i,
    output logic         pwm_o,
    output logic         wrap_pulse_o,
    output logic         match_pulse_o,
    output logic         busy_o
);

    typedef enum logic [1:0] {
        StIdle,
        StWaitWrap,
        StRun,
        StDone
    } state_e;

    localparam logic [N:0] DutyFull = {1'b1, {N{1'b0}}};

    state_e       state_q, state_d;
    logic [N-1:0] count_q;
    logic [N:0]   shadow_q, shadow_d;
    logic [N:0]   active_q, active_d;
    logic [N:0]   duty_eff;
    logic [N:0]   count_ext;
    logic         wrap;
    logic         transfer;
    logic         pwm_q, pwm_d;
    logic         wrap_pulse_q;
    logic         match_pulse_q, match_pulse_d;
    logic         busy_q, busy_d;

    // count_q resets to 0, so the upstream counter's own reset never looks like a wrap
    assign wrap      = (count_i == '0) && (count_q == '1);
    assign count_ext = {1'b0, count_i};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (en_i) state_d = StWaitWrap;
            end
            StWaitWrap: begin
                if (!en_i) begin
                    state_d = StIdle;
                end else if (wrap) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // en and mode are only honoured at a period boundary
                if (wrap) begin
                    if (!en_i) begin
                        state_d = StIdle;
                    end else if (mode_i) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (!en_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        transfer = wrap && (state_d == StRun);
        duty_eff = transfer ? shadow_q : active_q;
        active_d = duty_eff;

        shadow_d = shadow_q;
        if (duty_load_i) begin
            shadow_d = (duty_in_i > DutyFull) ? DutyFull : duty_in_i;
        end

        pwm_d         = (state_d == StRun) && (count_ext < duty_eff);
        match_pulse_d = (state_q == StRun) && (state_d == StRun) &&
                        (duty_eff != '0) && (duty_eff < DutyFull) &&
                        (count_ext == duty_eff);
        busy_d        = (state_d == StWaitWrap) || (state_d == StRun);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            count_q       <= '0;
            shadow_q      <= '0;
            active_q      <= '0;
            pwm_q         <= 1'b0;
            wrap_pulse_q  <= 1'b0;
            match_pulse_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_i;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            pwm_q         <= pwm_d;
            wrap_pulse_q  <= wrap;
            match_pulse_q <= match_pulse_d;
            busy_q        <= busy_d;
        end
    end

    assign pwm_o         = pwm_q;
    assign wrap_pulse_o  = wrap_pulse_q;
    assign match_pulse_o = match_pulse_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_count_pwm_compare.sv
// Bench for count_pwm_compare: directed scenarios plus randomized traffic, all
// compared against a cycle-level behavioural model of the compare stage.
module tb_count_pwm_compare;

    localparam int PIdle = 0;
    localparam int PWait = 1;
    localparam int PRun  = 2;
    localparam int PDone = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cnt;
    logic       en;
    logic       mode;
    logic [4:0] duty_in;
    logic       duty_load;
    logic       pwm_o, wrap_pulse_o, match_pulse_o, busy_o;

    int total = 0;
    int bad   = 0;
    int hi_cnt, match_cnt, wrap_cnt;

    int m_ph, m_prev, m_shadow, m_active;
    logic exp_pwm, exp_wrap, exp_match, exp_busy;

    always #5 clk = ~clk;

    count_pwm_compare #(.N(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .count_i      (cnt),
        .en_i         (en),
        .mode_i       (mode),
        .duty_in_i    (duty_in),
        .duty_load_i  (duty_load),
        .pwm_o        (pwm_o),
        .wrap_pulse_o (wrap_pulse_o),
        .match_pulse_o(match_pulse_o),
        .busy_o       (busy_o)
    );

    task automatic model_reset();
        m_ph = PIdle; m_prev = 0; m_shadow = 0; m_active = 0;
        exp_pwm = 0; exp_wrap = 0; exp_match = 0; exp_busy = 0;
    endtask

    // One clock of the reference: boundary = count going 15 -> 0.
    task automatic model_update();
        bit wr, xfer;
        int nph, de, c;
        c  = int'(cnt);
        wr = (c == 0) && (m_prev == 15);
        if (m_ph == PRun && !wr) nph = PRun;
        else if (!en)            nph = PIdle;
        else if (m_ph == PIdle)  nph = PWait;
        else if (m_ph == PWait)  nph = wr ? PRun : PWait;
        else if (m_ph == PRun)   nph = mode ? PDone : PRun;
        else                     nph = PDone;
        xfer = wr && (nph == PRun);
        de   = xfer ? m_shadow : m_active;
        exp_pwm   = (nph == PRun) && (c < de);
        exp_match = (m_ph == PRun) && (nph == PRun) && (de > 0) && (de < 16) && (c == de);
        exp_wrap  = wr;
        exp_busy  = (nph == PWait) || (nph == PRun);
        if (xfer) m_active = m_shadow;
        if (duty_load) m_shadow = (int'(duty_in) > 16) ? 16 : int'(duty_in);
        m_prev = c;
        m_ph   = nph;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        if (pwm_o) hi_cnt++;
        if (match_pulse_o) match_cnt++;
        if (wrap_pulse_o) wrap_cnt++;
        duty_load = 1'b0;
        cnt = cnt + 4'd1;
    endtask

    task automatic zero_tallies();
        hi_cnt = 0; match_cnt = 0; wrap_cnt = 0;
    endtask

    task automatic run_to_zero();
        for (int i = 0; i < 16 && cnt != 4'd0; i++) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 0; mode = 0; duty_in = 0; duty_load = 0; cnt = 0;
        model_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({pwm_o, wrap_pulse_o, match_pulse_o, busy_o} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0000",
                     {pwm_o, wrap_pulse_o, match_pulse_o, busy_o});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        duty_in = 5'd4; duty_load = 1;
        step();
        for (int i = 0; i < 16 && cnt != 4'd5; i++) step();
        en = 1; mode = 0;
        step();
        total++;
        if (busy_o !== 1'b1) begin
            bad++; $display("FAIL basic_busy_early: got %b want 1", busy_o);
        end
        run_to_zero();
        zero_tallies();
        for (int i = 0; i < 32; i++) begin
            step();
            total++;
            if ({pwm_o, wrap_pulse_o, match_pulse_o, busy_o} !==
                {exp_pwm, exp_wrap, exp_match, exp_busy}) begin
                bad++;
                $display("FAIL basic_cycle: got %b want %b",
                         {pwm_o, wrap_pulse_o, match_pulse_o, busy_o},
                         {exp_pwm, exp_wrap, exp_match, exp_busy});
            end
        end
        total++;
        if (hi_cnt != 8 || match_cnt != 2 || wrap_cnt != 2) begin
            bad++;
            $display("FAIL basic_tally: got hi=%0d match=%0d wrap=%0d want 8 2 2",
                     hi_cnt, match_cnt, wrap_cnt);
        end
    endtask

    task automatic test_full_zero();
        duty_in = 5'd20; duty_load = 1;  // clamps to 16
        step();
        run_to_zero();
        duty_in = 5'd0; duty_load = 1;
        for (int p = 0; p < 2; p++) begin
            zero_tallies();
            for (int i = 0; i < 16; i++) begin
                step();
                total++;
                if ({pwm_o, wrap_pulse_o, match_pulse_o, busy_o} !==
                    {exp_pwm, exp_wrap, exp_match, exp_busy}) begin
                    bad++;
                    $display("FAIL full_zero_cycle: got %b want %b",
                             {pwm_o, wrap_pulse_o, match_pulse_o, busy_o},
                             {exp_pwm, exp_wrap, exp_match, exp_busy});
                end
            end
            total++;
            if (hi_cnt != (p == 0 ? 16 : 0) || match_cnt != 0) begin
                bad++;
                $display("FAIL full_zero_tally p%0d: got hi=%0d match=%0d want %0d 0",
                         p, hi_cnt, match_cnt, (p == 0 ? 16 : 0));
            end
        end
    endtask

    task automatic test_load_on_wrap();
        duty_in = 5'd8; duty_load = 1;
        step();
        run_to_zero();
        duty_in = 5'd2; duty_load = 1;
        for (int p = 0; p < 2; p++) begin
            zero_tallies();
            for (int i = 0; i < 16; i++) begin
                step();
                total++;
                if ({pwm_o, wrap_pulse_o, match_pulse_o, busy_o} !==
                    {exp_pwm, exp_wrap, exp_match, exp_busy}) begin
                    bad++;
                    $display("FAIL load_on_wrap_cycle: got %b want %b",
                             {pwm_o, wrap_pulse_o, match_pulse_o, busy_o},
                             {exp_pwm, exp_wrap, exp_match, exp_busy});
                end
            end
            total++;
            if (hi_cnt != (p == 0 ? 8 : 2)) begin
                bad++;
                $display("FAIL load_on_wrap_tally p%0d: got hi=%0d want %0d",
                         p, hi_cnt, (p == 0 ? 8 : 2));
            end
        end
    endtask

    task automatic test_oneshot();
        en = 0;
        step();
        mode = 1; duty_in = 5'd8; duty_load = 1; en = 1;
        for (int r = 0; r < 2; r++) begin
            zero_tallies();
            for (int i = 0; i < 48; i++) begin
                step();
                total++;
                if ({pwm_o, wrap_pulse_o, match_pulse_o, busy_o} !==
                    {exp_pwm, exp_wrap, exp_match, exp_busy}) begin
                    bad++;
                    $display("FAIL oneshot_cycle: got %b want %b",
                             {pwm_o, wrap_pulse_o, match_pulse_o, busy_o},
                             {exp_pwm, exp_wrap, exp_match, exp_busy});
                end
            end
            total++;
            if (hi_cnt != 8 || busy_o !== 1'b0) begin
                bad++;
                $display("FAIL oneshot_pulse r%0d: got hi=%0d busy=%b want 8 0",
                         r, hi_cnt, busy_o);
            end
            en = 0;
            step();
            step();
            en = 1;
        end
    endtask

    task automatic test_drop_en();
        en = 0;
        step();
        mode = 0; duty_in = 5'd6; duty_load = 1; en = 1;
        run_to_zero();
        zero_tallies();
        step();
        step();
        en = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            total++;
            if ({pwm_o, busy_o} !== {exp_pwm, exp_busy}) begin
                bad++;
                $display("FAIL drop_en_cycle: got pwm/busy=%b want %b",
                         {pwm_o, busy_o}, {exp_pwm, exp_busy});
            end
        end
        step();
        total++;
        if (pwm_o !== 1'b0 || busy_o !== 1'b0 || hi_cnt != 6) begin
            bad++;
            $display("FAIL drop_en_idle: got pwm=%b busy=%b hi=%0d want 0 0 6",
                     pwm_o, busy_o, hi_cnt);
        end
    endtask

    task automatic test_mid_reset();
        en = 1; mode = 0; duty_in = 5'd8; duty_load = 1;
        run_to_zero();
        step();
        step();
        step();
        total++;
        if (pwm_o !== 1'b1) begin
            bad++; $display("FAIL mid_reset_pre: got pwm=%b want 1", pwm_o);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({pwm_o, wrap_pulse_o, match_pulse_o, busy_o} !== 4'b0000) begin
            bad++;
            $display("FAIL mid_reset_async: got %b want 0000",
                     {pwm_o, wrap_pulse_o, match_pulse_o, busy_o});
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        cnt = cnt + 4'd1;
        rst_n = 1'b1;
        zero_tallies();
        for (int i = 0; i < 40; i++) begin
            step();
            total++;
            if ({pwm_o, wrap_pulse_o, match_pulse_o, busy_o} !==
                {exp_pwm, exp_wrap, exp_match, exp_busy}) begin
                bad++;
                $display("FAIL mid_reset_cycle: got %b want %b",
                         {pwm_o, wrap_pulse_o, match_pulse_o, busy_o},
                         {exp_pwm, exp_wrap, exp_match, exp_busy});
            end
        end
        total++;
        if (hi_cnt != 0) begin
            bad++; $display("FAIL mid_reset_no_pwm: got hi=%0d want 0", hi_cnt);
        end
        duty_in = 5'd5; duty_load = 1;
        step();
        run_to_zero();
        zero_tallies();
        repeat (16) step();
        total++;
        if (hi_cnt != 5) begin
            bad++; $display("FAIL mid_reset_reload: got hi=%0d want 5", hi_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) en = ~en;
            if ($urandom_range(0, 39) == 0) mode = ~mode;
            if ($urandom_range(0, 7) == 0) begin
                duty_in = 5'($urandom_range(0, 31));
                duty_load = 1;
            end
            step();
            total++;
            if ({pwm_o, wrap_pulse_o, match_pulse_o, busy_o} !==
                {exp_pwm, exp_wrap, exp_match, exp_busy}) begin
                bad++;
                $display("FAIL random_cycle %0d: got %b want %b", i,
                         {pwm_o, wrap_pulse_o, match_pulse_o, busy_o},
                         {exp_pwm, exp_wrap, exp_match, exp_busy});
            end
            // occasional upstream glitch; must only suppress wrap detection
            if ($urandom_range(0, 63) == 0) cnt = 4'($urandom_range(0, 15));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        zero_tallies();
        test_reset();
        test_basic();
        test_full_zero();
        test_load_on_wrap();
        test_oneshot();
        test_drop_en();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
